// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// Signed operations run on magnitudes and apply the sign correction in a single FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [1:0]       OP,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] out_HI,
    output logic [WIDTH-1:0] out_LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opb;
    logic                   r_is_div;
    logic                   r_neg_res;
    logic                   r_neg_rem;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_div_zero;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic                   w_sign_a;
    logic                   w_sign_b;
    logic                   w_b_zero;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_diff;
    logic                   w_qbit;
    logic [2*WIDTH-1:0]     w_calc_next;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_lo;

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? f_neg_w(v) : v;
    endfunction

    assign w_sign_a = OP[0] & in_A[WIDTH-1];
    assign w_sign_b = OP[0] & in_B[WIDTH-1];
    assign w_b_zero = (in_B == {WIDTH{1'b0}});

    // Next-state logic for the IDLE/CALC/FIX/DONE sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (OP[1] && w_b_zero) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_CALC;
                end
            end
            S_FIX:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // One iteration step: multiply keeps the multiplier in the low half, divide keeps the quotient there
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_qbit      = ~w_div_diff[WIDTH];
        if (r_is_div) begin
            w_calc_next = {(w_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                           r_acc[WIDTH-2:0], w_qbit};
        end else begin
            w_calc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the raw magnitude result
    always_comb begin
        w_prod_fix = r_neg_res ? f_neg_2w(r_acc) : r_acc;
        if (r_is_div) begin
            w_fix_lo = r_neg_res ? f_neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_rem ? f_neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        end else begin
            w_fix_lo = w_prod_fix[WIDTH-1:0];
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_CALC) || (w_next_state == S_FIX);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_acc      <= {(2*WIDTH){1'b0}};
            r_opb      <= {WIDTH{1'b0}};
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= {CNT_W{1'b0}};
                        r_is_div  <= OP[1];
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
                        if (OP[1]) begin
                            r_opb <= f_mag(in_B, w_sign_b);
                            r_acc <= {{WIDTH{1'b0}}, f_mag(in_A, w_sign_a)};
                        end else begin
                            r_opb <= f_mag(in_A, w_sign_a);
                            r_acc <= {{WIDTH{1'b0}}, f_mag(in_B, w_sign_b)};
                        end
                        // Divide by zero completes immediately with the fixed result pattern
                        if (OP[1] && w_b_zero) begin
                            r_div_zero <= 1'b1;
                            r_hi       <= in_A;
                            r_lo       <= {WIDTH{1'b1}};
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_calc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi       <= w_fix_hi;
                    r_lo       <= w_fix_lo;
                    r_div_zero <= 1'b0;
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign out_HI   = r_hi;
    assign out_LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written reset sequence,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [1:0]  OP;
    logic        start;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] out_HI;
    logic [31:0] out_LO;

    int checks;
    int errors;

    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic        prev_dz;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          respin;
        bit          done_start;
    } vec_t;

    vec_t tbl[11];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_A     (in_A),
        .in_B     (in_B),
        .OP       (OP),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .out_HI   (out_HI),
        .out_LO   (out_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural operands
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = 64'd0;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'd0: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                q  = sa * sb;
                p  = q;
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = q;
                    lo = p[31:0];
                    p  = r;
                    hi = p[31:0];
                end
            end
        endcase
    endfunction

    task automatic scramble();
        in_A = $urandom;
        in_B = $urandom;
        OP   = 2'($urandom_range(0, 3));
    endtask

    // Issue one operation and check every cycle until it completes
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int respin, input bit done_start);
        int lat;
        logic [1:0] exp_bd;
        lat = (op[1] && b == 32'd0) ? 1 : 34;
        @(negedge clk);
        OP = op; in_A = a; in_B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            exp_bd = {(lat == 34 && k < 34), (k == lat)};
            chk({name, " busy/done"}, {94'd0, busy, done}, {94'd0, exp_bd});
            if (k < lat) begin
                chk({name, " hold"}, {31'd0, div_zero, out_HI, out_LO}, {31'd0, prev_dz, prev_hi, prev_lo});
            end else begin
                chk({name, " result"}, {31'd0, div_zero, out_HI, out_LO}, {31'd0, edz, ehi, elo});
            end
            start = (k == respin) || (k == lat && done_start);
            if (k == respin) scramble();
        end
        @(negedge clk);
        chk({name, " idle after done"}, {94'd0, busy, done}, 96'd0);
        start = 1'b0;
        prev_hi = ehi;
        prev_lo = elo;
        prev_dz = edz;
    endtask

    initial begin
        logic [31:0] rhi, rlo, ra, rb;
        logic        rdz;
        logic [1:0]  rop;
        int          mode;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        in_A   = 32'd0;
        in_B   = 32'd0;
        OP     = 2'd0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        prev_dz = 1'b0;

        tbl[0]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, 1'b0};
        tbl[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 1'b1};
        tbl[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0};
        tbl[3]  = '{2'd2, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 0, 1'b0};
        tbl[4]  = '{2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0, 1'b0};
        tbl[5]  = '{2'd0, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A, 1'b0, 5, 1'b0};
        tbl[6]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1'b0};
        tbl[7]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1'b0};
        tbl[8]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 1'b0};
        tbl[9]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 1'b1};
        tbl[10] = '{2'd2, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset state", {29'd0, busy, done, div_zero, out_HI, out_LO}, 96'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].respin, tbl[i].done_start);
        end

        // Reset in the middle of a signed divide
        @(negedge clk);
        OP = 2'd3; in_A = 32'hFFFF_FFF9; in_B = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid-op busy", {95'd0, busy}, 96'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid-op reset", {29'd0, busy, done, div_zero, out_HI, out_LO}, 96'd0);
        reset = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        prev_dz = 1'b0;
        run_op("after reset", 2'd0, 32'd3, 32'd4, 32'd0, 32'h0000_000C, 1'b0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                rb = 32'd0;
            end else if (mode == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (mode == 2) begin
                rb = 32'($urandom_range(1, 15));
            end else if (mode == 3) begin
                rb = 32'h8000_0000 | 32'($urandom_range(0, 3));
            end
            model(rop, ra, rb, rhi, rlo, rdz);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rhi, rlo, rdz,
                   (i % 4 == 1) ? int'($urandom_range(2, 30)) : 0, (i % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
